// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the word PC, fetches over a req/ack handshake and presents
// (if_ins, pc_plus_4) to IF/ID, absorbing stalls with a one-entry skid and redirects via DRAIN.
module if_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_ins,
  output logic [29:0] pc_plus_4,
  output logic        fetch_bubble
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] drain_addr_q, drain_addr_d;
  logic [29:0] pc4_q, pc4_d;
  logic [31:0] ins_q, ins_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [29:0] skid_pc4_q, skid_pc4_d;

  logic consume;
  logic ack;

  assign consume      = out_valid_q & ~stall & ~redirect_valid;
  assign imem_req     = ~rst & (state_q != HOLD);
  assign ack          = imem_ack & imem_req;
  assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign if_ins       = out_valid_q ? ins_q : NOP_INS;
  assign pc_plus_4    = pc4_q;
  assign fetch_bubble = ~out_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    pc4_d        = pc4_q;
    ins_d        = ins_q;
    out_valid_d  = out_valid_q;
    skid_ins_d   = skid_ins_q;
    skid_pc4_d   = skid_pc4_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // An unacked request must finish at its original address before we move on.
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          if (!ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (ack) begin
          pc_d = pc_q + 30'd1;
          if (!out_valid_q || consume) begin
            ins_d       = imem_rdata;
            pc4_d       = pc_q + 30'd1;
            out_valid_d = 1'b1;
          end else begin
            skid_ins_d = imem_rdata;
            skid_pc4_d = pc_q + 30'd1;
            state_d    = HOLD;
          end
        end else if (consume) begin
          out_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          skid_ins_d  = NOP_INS;
          skid_pc4_d  = '0;
          state_d     = FETCH;
        end else if (consume) begin
          ins_d   = skid_ins_q;
          pc4_d   = skid_pc4_q;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (ack) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      pc4_q        <= RESET_PC + 30'd1;
      ins_q        <= NOP_INS;
      out_valid_q  <= 1'b0;
      skid_ins_q   <= NOP_INS;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      pc4_q        <= pc4_d;
      ins_q        <= ins_d;
      out_valid_q  <= out_valid_d;
      skid_ins_q   <= skid_ins_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: the expected stream is "consecutive words from the last reset/redirect
// target", kept in a scoreboard queue and popped whenever IF/ID would capture an instruction.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_ins;
  logic [29:0] pc_plus_4;
  logic        fetch_bubble;

  logic        w_req;
  logic [29:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_ins;
  logic [29:0] w_pc4;
  logic        w_bubble;

  if_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_ins        (if_ins),
    .pc_plus_4     (pc_plus_4),
    .fetch_bubble  (fetch_bubble)
  );

  // Second instance starting at the top of the address space, zero-wait memory returning addr.
  if_fetch_unit #(.RESET_PC(30'h3FFF_FFFF), .NOP_INS(32'h0000_0000)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .stall         (1'b0),
    .redirect_valid(1'b0),
    .redirect_pc   (30'h0),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .if_ins        (w_ins),
    .pc_plus_4     (w_pc4),
    .fetch_bubble  (w_bubble)
  );

  assign w_ack   = w_req;
  assign w_rdata = {2'b00, w_addr};

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] ins;
    logic [29:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [29:0] next_pc;

  function automatic void restart(input logic [29:0] a);
    exp_q.delete();
    next_pc = a;
  endfunction

  function automatic void top_up();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.ins = mem_word(next_pc);
      e.pc4 = next_pc + 30'd1;
      exp_q.push_back(e);
      next_pc = next_pc + 30'd1;
    end
  endfunction

  // Memory: mem_lat wait cycles before ack (negative = random 0..3); checks address stability.
  int          mem_lat = 0;
  bit          in_req = 1'b0;
  int          wait_left = 0;
  logic [29:0] req_addr = '0;

  always begin
    @(negedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    if (rst) begin
      in_req = 1'b0;
    end else if (imem_req) begin
      if (!in_req) begin
        in_req    = 1'b1;
        req_addr  = imem_addr;
        wait_left = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
      end else begin
        checkOutput("addr_stable", {2'b00, imem_addr}, {2'b00, req_addr});
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        in_req     = 1'b0;
      end else begin
        wait_left--;
      end
    end
  end

  // Monitor: pops the scoreboard on every cycle IF/ID captures, and checks hold/bubble rules.
  int          consumed = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] held_ins;
  logic [29:0] held_pc4;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("held_valid", {31'b0, ~fetch_bubble}, 32'd1);
        checkOutput("held_ins", if_ins, held_ins);
        checkOutput("held_pc4", {2'b00, pc_plus_4}, {2'b00, held_pc4});
      end
      if (fetch_bubble) begin
        checkOutput("bubble_nop", if_ins, NOP);
      end else if (!stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_empty: got ins %h with nothing expected", if_ins);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_ins", if_ins, e.ins);
          checkOutput("sb_pc4", {2'b00, pc_plus_4}, {2'b00, e.pc4});
        end
        consumed++;
      end
      prev_hold = !fetch_bubble && stall && !redirect_valid;
      held_ins  = if_ins;
      held_pc4  = pc_plus_4;
    end
  end

  task automatic applyStimulus(input bit s, input bit rv, input logic [29:0] rpc);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) restart(rpc);
    top_up();
    #3;
  endtask

  task automatic setReset(input bit r);
    @(negedge clk);
    rst            = r;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    if (r) restart(30'h0);
    top_up();
    #3;
  endtask

  initial begin
    bit          got;
    int          base;
    logic [29:0] a1;
    logic [29:0] d_addr;
    logic [31:0] r;
    bit          s;
    bit          rv;
    logic [29:0] rpc;

    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart(30'h0);
    top_up();

    // Reset values
    setReset(1'b1);
    setReset(1'b1);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("rst_ins", if_ins, NOP);
    checkOutput("rst_pc4", {2'b00, pc_plus_4}, 32'd1);
    checkOutput("wrap_rst_pc4", {2'b00, w_pc4}, 32'd0);

    // Zero-wait streaming
    setReset(1'b0);
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", {2'b00, imem_addr}, 32'd0);
    checkOutput("first_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("wrap_addr0", {2'b00, w_addr}, 32'h3FFF_FFFF);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("s2_bubble", {31'b0, fetch_bubble}, 32'd0);
    checkOutput("s2_ins", if_ins, mem_word(30'd0));
    checkOutput("s2_pc4", {2'b00, pc_plus_4}, 32'd1);
    checkOutput("wrap_addr1", {2'b00, w_addr}, 32'd0);
    checkOutput("wrap_ins", w_ins, 32'h3FFF_FFFF);
    checkOutput("wrap_pc4", {2'b00, w_pc4}, 32'd0);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("s3_ins", if_ins, mem_word(30'd1));
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("s4_ins", if_ins, mem_word(30'd2));
    checkOutput("s4_pc4", {2'b00, pc_plus_4}, 32'd3);

    // Four-cycle stall: one fetch lands in the skid, then requests stop
    applyStimulus(1'b1, 1'b0, 30'h0);
    checkOutput("st1_ins", if_ins, mem_word(30'd3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h0);
      checkOutput("hold_req", {31'b0, imem_req}, 32'd0);
      checkOutput("hold_ins", if_ins, mem_word(30'd3));
    end
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("unst_ins", if_ins, mem_word(30'd3));
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("skid_ins", if_ins, mem_word(30'd4));
    checkOutput("skid_pc4", {2'b00, pc_plus_4}, 32'd5);
    checkOutput("skid_addr", {2'b00, imem_addr}, 32'd5);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("after_skid_ins", if_ins, mem_word(30'd5));

    // Three-cycle memory latency
    mem_lat = 2;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      applyStimulus(1'b0, 1'b0, 30'h0);
      if (imem_ack) got = 1'b1;
    end
    checkOutput("lat_ack_seen", {31'b0, got}, 32'd1);
    applyStimulus(1'b0, 1'b0, 30'h0);
    a1 = imem_addr;
    checkOutput("lat_a1_bubble", {31'b0, fetch_bubble}, 32'd0);
    checkOutput("lat_a1_ack", {31'b0, imem_ack}, 32'd0);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("lat_a2_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("lat_a2_addr", {2'b00, imem_addr}, {2'b00, a1});
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("lat_a3_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("lat_a3_ack", {31'b0, imem_ack}, 32'd1);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("lat_a4_ins", if_ins, mem_word(a1));

    // Redirect while a request is outstanding -> drain at the old address
    applyStimulus(1'b0, 1'b1, 30'h100);
    d_addr = imem_addr;
    checkOutput("rd_pre_ack", {31'b0, imem_ack}, 32'd0);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("drain_req", {31'b0, imem_req}, 32'd1);
    checkOutput("drain_addr", {2'b00, imem_addr}, {2'b00, d_addr});
    checkOutput("drain_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("drain_ins", if_ins, NOP);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("rd_new_addr", {2'b00, imem_addr}, 32'h100);
    checkOutput("rd_new_bubble", {31'b0, fetch_bubble}, 32'd1);
    applyStimulus(1'b0, 1'b0, 30'h0);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("rd_wait_bubble", {31'b0, fetch_bubble}, 32'd1);
    mem_lat = 0;
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("rd_ins", if_ins, mem_word(30'h100));
    checkOutput("rd_pc4", {2'b00, pc_plus_4}, 32'h101);

    // Redirect coincident with ack and stall
    applyStimulus(1'b1, 1'b1, 30'h200);
    checkOutput("rsa_ack", {31'b0, imem_ack}, 32'd1);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("rsa_addr", {2'b00, imem_addr}, 32'h200);
    checkOutput("rsa_bubble", {31'b0, fetch_bubble}, 32'd1);
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("rsa_ins", if_ins, mem_word(30'h200));
    checkOutput("rsa_pc4", {2'b00, pc_plus_4}, 32'h201);

    // Reset while in HOLD
    applyStimulus(1'b1, 1'b0, 30'h0);
    applyStimulus(1'b1, 1'b0, 30'h0);
    checkOutput("hr_hold_req", {31'b0, imem_req}, 32'd0);
    setReset(1'b1);
    checkOutput("hr_rst_req", {31'b0, imem_req}, 32'd0);
    setReset(1'b1);
    checkOutput("hr_bubble", {31'b0, fetch_bubble}, 32'd1);
    checkOutput("hr_ins", if_ins, NOP);
    checkOutput("hr_pc4", {2'b00, pc_plus_4}, 32'd1);
    setReset(1'b0);
    checkOutput("hr_req", {31'b0, imem_req}, 32'd1);
    checkOutput("hr_addr", {2'b00, imem_addr}, 32'd0);

    // Randomized traffic
    mem_lat = -1;
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(99, 0) < 30);
      rv = ($urandom_range(99, 0) < 4);
      r  = $urandom();
      rpc = ($urandom_range(3, 0) == 0) ? 30'h3FFF_FFFE : r[29:0];
      applyStimulus(s, rv, rpc);
    end
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkOutput("progress", {31'b0, (consumed - base) >= 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
